// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the N-requester round-robin arbiter.
package rr_arb_pkg;

    localparam int RR_MAX_N = 32;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } rr_state_e;

    // Modulo-n increment of a requester index.
    function automatic int rr_next_idx(input int idx, input int n);
        int nxt;
        if (idx + 32'sd1 >= n) begin
            nxt = 32'sd0;
        end else begin
            nxt = idx + 32'sd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr, wrapping to 0.
module rr_arb_pick
    import rr_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N-1:0]     mask_s;
    logic [N-1:0]     hi_s;
    logic [N-1:0]     src_s;
    logic [N-1:0]     onehot_s;
    logic [IDX_W-1:0] idx_s;

    // Requests at or above ptr win first; otherwise the lowest request wraps around.
    always_comb begin
        mask_s = '0;
        idx_s  = '0;
        for (int i = 0; i < N; i++) begin
            mask_s[i] = (IDX_W'(i) >= ptr);
        end
        hi_s     = req & mask_s;
        src_s    = (|hi_s) ? hi_s : req;
        onehot_s = src_s & (~src_s + {{(N-1){1'b0}}, 1'b1});
        for (int i = 0; i < N; i++) begin
            idx_s = idx_s | (onehot_s[i] ? IDX_W'(i) : {IDX_W{1'b0}});
        end
    end

    assign onehot = onehot_s;
    assign idx    = idx_s;
    assign any    = |req;

endmodule

// File: rtl/round_robin_arbiter_n.sv
// N-requester round-robin arbiter with capped burst lock.
// Define RR_ARB_GRANT_REG_EN to register grants/grant_valid/grant_idx (1-cycle latency).
module round_robin_arbiter_n
    import rr_arb_pkg::*;
#(
    parameter  int N         = 4,
    parameter  int MAX_BURST = 4,
    localparam int IDX_W     = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     requests,
    input  logic             lock,
    output logic [N-1:0]     grants,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    localparam int               CNT_W       = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [CNT_W-1:0] MAX_BURST_C = CNT_W'(MAX_BURST);

    rr_state_e        state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic [N-1:0]     pick_onehot_s;
    logic [IDX_W-1:0] pick_idx_s;
    logic             pick_any_s;
    logic             cap_ok_s;
    logic             hold_s;
    logic [CNT_W-1:0] burst_inc_s;
    logic [N-1:0]     grant_oh_s;
    logic [IDX_W-1:0] grant_idx_s;

    rr_arb_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (requests),
        .ptr    (ptr_q),
        .onehot (pick_onehot_s),
        .idx    (pick_idx_s),
        .any    (pick_any_s)
    );

    assign cap_ok_s    = (MAX_BURST == 0) || (burst_cnt_q < MAX_BURST_C);
    assign hold_s      = (state_q == LOCKED) && requests[owner_q] && lock && cap_ok_s;
    assign burst_inc_s = burst_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // Next-state and grant selection; a failed hold falls through to normal arbitration in the same cycle.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        grant_oh_s  = '0;
        grant_idx_s = '0;
        if (hold_s) begin
            grant_oh_s  = {{(N-1){1'b0}}, 1'b1} << owner_q;
            grant_idx_s = owner_q;
            ptr_d       = IDX_W'(rr_next_idx(int'(owner_q), N));
            burst_cnt_d = (&burst_cnt_q) ? burst_cnt_q : burst_inc_s;
            if ((MAX_BURST != 0) && (burst_inc_s == MAX_BURST_C)) begin
                state_d = ARB;
            end else begin
                state_d = LOCKED;
            end
        end else if (pick_any_s) begin
            grant_oh_s  = pick_onehot_s;
            grant_idx_s = pick_idx_s;
            ptr_d       = IDX_W'(rr_next_idx(int'(pick_idx_s), N));
            if (lock && (MAX_BURST != 1)) begin
                state_d     = LOCKED;
                owner_d     = pick_idx_s;
                burst_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                state_d     = ARB;
                burst_cnt_d = '0;
            end
        end else begin
            state_d     = ARB;
            burst_cnt_d = '0;
        end
        // Outputs read zero while reset is held, even with requests present.
        if (!rst) begin
            grant_oh_s  = '0;
            grant_idx_s = '0;
        end else begin
            grant_oh_s  = grant_oh_s;
            grant_idx_s = grant_idx_s;
        end
    end

    // Arbitration state flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ARB;
            ptr_q       <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

`ifdef RR_ARB_GRANT_REG_EN
    logic [N-1:0]     grants_q;
    logic             grant_valid_q;
    logic [IDX_W-1:0] grant_idx_q;

    // Registered copy of the combinational grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grants_q      <= '0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
        end else begin
            grants_q      <= grant_oh_s;
            grant_valid_q <= |grant_oh_s;
            grant_idx_q   <= grant_idx_s;
        end
    end

    assign grants      = grants_q;
    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;
`else
    assign grants      = grant_oh_s;
    assign grant_valid = |grant_oh_s;
    assign grant_idx   = grant_idx_s;
`endif

endmodule

// File: tb/tb_round_robin_arbiter_n.sv
// Directed bench for round_robin_arbiter_n (N=4, MAX_BURST=3); honours RR_ARB_GRANT_REG_EN.
module tb_round_robin_arbiter_n;

    logic       clk;
    logic       rst;
    logic [3:0] requests;
    logic       lock;
    logic [3:0] grants;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic [3:0] prev_req;

    int checks = 0;
    int errors = 0;

    round_robin_arbiter_n #(
        .N         (4),
        .MAX_BURST (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .requests    (requests),
        .lock        (lock),
        .grants      (grants),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) prev_req <= requests;

    // Continuous properties: one-hot-or-zero, and only requesters (current or previous cycle) granted.
    always @(negedge clk) begin
        if (rst) begin
            checks = checks + 1;
            assert ($onehot0(grants)) else begin
                errors = errors + 1;
                $error("FAIL onehot0 grants=%b", grants);
            end
            checks = checks + 1;
            assert ((grants & ~(requests | prev_req)) === 4'b0000) else begin
                errors = errors + 1;
                $error("FAIL subset grants=%b requests=%b prev=%b", grants, requests, prev_req);
            end
        end
    end

    task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] ei);
        checks = checks + 1;
        assert (grants === eg) else begin
            errors = errors + 1;
            $error("FAIL %s grants got=%b exp=%b", tag, grants, eg);
        end
        checks = checks + 1;
        assert (grant_valid === (|eg)) else begin
            errors = errors + 1;
            $error("FAIL %s grant_valid got=%b exp=%b", tag, grant_valid, |eg);
        end
        checks = checks + 1;
        assert (grant_idx === ei) else begin
            errors = errors + 1;
            $error("FAIL %s grant_idx got=%0d exp=%0d", tag, grant_idx, ei);
        end
    endtask

    // Drive one cycle; the expected grant is the arbitration result of this cycle's inputs.
    task automatic step(input logic [3:0] req, input logic lk,
                        input logic [3:0] eg, input logic [1:0] ei, input string tag);
        requests = req;
        lock     = lk;
        #2;
`ifndef RR_ARB_GRANT_REG_EN
        chk(tag, eg, ei);
`endif
        @(posedge clk);
        #1;
`ifdef RR_ARB_GRANT_REG_EN
        chk(tag, eg, ei);
`endif
    endtask

    task automatic do_reset(input string tag);
        requests = 4'b0000;
        lock     = 1'b0;
        rst      = 1'b0;
        #2;
        chk(tag, 4'b0000, 2'd0);
        rst = 1'b1;
        #1;
        chk({tag, "_rel"}, 4'b0000, 2'd0);
    endtask

    initial begin
        rst      = 1'b0;
        requests = 4'b0000;
        lock     = 1'b0;
        @(posedge clk);
        #1;

        // Test 1: full requests rotate
        do_reset("t1_rst");
        step(4'b1111, 1'b0, 4'b0001, 2'd0, "t1_c0");
        step(4'b1111, 1'b0, 4'b0010, 2'd1, "t1_c1");
        step(4'b1111, 1'b0, 4'b0100, 2'd2, "t1_c2");
        step(4'b1111, 1'b0, 4'b1000, 2'd3, "t1_c3");
        step(4'b1111, 1'b0, 4'b0001, 2'd0, "t1_c4");

        // Test 2: sparse requests, wrap and idle cycle
        do_reset("t2_rst");
        step(4'b0101, 1'b0, 4'b0001, 2'd0, "t2_c0");
        step(4'b0101, 1'b0, 4'b0100, 2'd2, "t2_c1");
        step(4'b0100, 1'b0, 4'b0100, 2'd2, "t2_c2");
        step(4'b0000, 1'b0, 4'b0000, 2'd0, "t2_c3");
        step(4'b1001, 1'b0, 4'b1000, 2'd3, "t2_c4");

        // Test 3: burst cap of 3 forces rotation
        do_reset("t3_rst");
        step(4'b1111, 1'b1, 4'b0001, 2'd0, "t3_c0");
        step(4'b1111, 1'b1, 4'b0001, 2'd0, "t3_c1");
        step(4'b1111, 1'b1, 4'b0001, 2'd0, "t3_c2");
        step(4'b1111, 1'b1, 4'b0010, 2'd1, "t3_c3");
        step(4'b1111, 1'b1, 4'b0010, 2'd1, "t3_c4");
        step(4'b1111, 1'b1, 4'b0010, 2'd1, "t3_c5");
        step(4'b1111, 1'b1, 4'b0100, 2'd2, "t3_c6");

        // Test 4: owner drops request, same-cycle re-arbitration
        do_reset("t4_rst");
        step(4'b0100, 1'b1, 4'b0100, 2'd2, "t4_c0");
        step(4'b1011, 1'b1, 4'b1000, 2'd3, "t4_c1");
        step(4'b1011, 1'b1, 4'b1000, 2'd3, "t4_c2");
        step(4'b1011, 1'b0, 4'b0001, 2'd0, "t4_c3");

        // Test 5: asynchronous reset mid-lock
        do_reset("t5_rst");
        step(4'b1111, 1'b1, 4'b0001, 2'd0, "t5_c0");
        step(4'b1111, 1'b1, 4'b0001, 2'd0, "t5_c1");
        rst = 1'b0;
        #1;
        chk("t5_async", 4'b0000, 2'd0);
        requests = 4'b0000;
        lock     = 1'b0;
        rst      = 1'b1;
        #1;
        step(4'b0110, 1'b0, 4'b0010, 2'd1, "t5_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
